// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader.
// BOOT_CHECKSUM_EN adds the trailing checksum state.
package boot_pkg;
   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      FLUSH,
`ifdef BOOT_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;
endpackage

// File: rtl/byte_packer.sv
// Packs four stream bytes into a little-endian 32-bit word.
// Pulses o_word_valid on the byte that completes a word.
module byte_packer
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_take,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);
   logic [1:0]  r_idx;
   logic [23:0] r_acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_take) begin
         r_idx <= r_idx + 2'd1;
         r_acc <= {i_byte, r_acc[23:8]};
      end
   end

   // Earlier bytes sit in the low lanes; the closing byte lands in [31:24]
   assign o_word_valid = i_take && (r_idx == 2'(BYTES_PER_WORD - 1));
   assign o_word       = {i_byte, r_acc};
endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory, then releases the core.
// BOOT_CHECKSUM_EN appends an XOR checksum byte that must match.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_len_lo;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_wl;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              w_rdy;
   logic              w_take;
   logic [LEN_W-1:0]  w_n;
   logic              w_too_big;
   logic              w_word;
   logic [31:0]       w_word_d;
   logic              w_last;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   assign w_take    = in_valid && in_ready;
   assign w_n       = {in_data, r_len_lo};
   assign w_too_big = 32'(w_n) > (32'd1 << ADDR_W);
   assign w_last    = (r_wl + (ADDR_W+1)'(1)) == r_len;

   byte_packer u_pack (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (r_state != DATA),
      .i_take       (w_take && (r_state == DATA)),
      .i_byte       (in_data),
      .o_word_valid (w_word),
      .o_word       (w_word_d)
   );

   always_comb begin
      w_next = r_state;
      w_rdy  = 1'b0;
      unique case (r_state)
         LEN_LO: begin
            w_rdy = 1'b1;
            if (w_take) w_next = LEN_HI;
         end
         LEN_HI: begin
            w_rdy = 1'b1;
            if (w_take) begin
               if (w_too_big)
                  w_next = ERR;
               else if (w_n == '0)
`ifdef BOOT_CHECKSUM_EN
                  w_next = CHK;
`else
                  w_next = DONE;
`endif
               else
                  w_next = DATA;
            end
         end
         DATA: begin
            w_rdy = 1'b1;
            if (w_word && w_last) w_next = FLUSH;
         end
         // Last strobe in flight; hold input off until it lands
         FLUSH: begin
`ifdef BOOT_CHECKSUM_EN
            w_next = CHK;
`else
            w_next = DONE;
`endif
         end
`ifdef BOOT_CHECKSUM_EN
         CHK: begin
            w_rdy = 1'b1;
            if (w_take) w_next = (in_data == r_sum) ? DONE : ERR;
         end
`endif
         DONE:    w_next = DONE;
         ERR:     w_next = ERR;
         default: w_next = ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= LEN_LO;
         r_len_lo <= '0;
         r_len    <= '0;
         r_wl     <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         r_we    <= w_word;
         if (w_take && r_state == LEN_LO) r_len_lo <= in_data;
         if (w_take && r_state == LEN_HI) r_len <= w_n[ADDR_W:0];
         if (w_word) begin
            r_addr  <= r_wl[ADDR_W-1:0];
            r_wdata <= w_word_d;
            r_wl    <= r_wl + (ADDR_W+1)'(1);
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_sum <= '0;
      else if (w_take && (r_state == LEN_LO || r_state == LEN_HI ||
                          r_state == DATA))
         r_sum <= r_sum ^ in_data;
   end
`endif

   assign in_ready     = w_rdy && rst;
   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign done         = r_state == DONE;
   assign err          = r_state == ERR;
   assign cpu_rst      = r_state != DONE;
   assign words_loaded = r_wl;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: image load, empty image, oversize,
// throttled input, mid-load abort and (with BOOT_CHECKSUM_EN) checksum.
module tb_imem_boot_loader;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int checks = 0;
   int errors = 0;
   int wr_n = 0;
   int ovl = 0;
   logic [ADDR_W-1:0] wr_a [8];
   logic [31:0]       wr_d [8];
   logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                            8'h00, 8'h08, 8'h00, 8'h00, 8'h00};

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst)
         wr_n = 0;
      else if (imem_we) begin
         if (wr_n < 8) begin
            wr_a[wr_n] = imem_addr;
            wr_d[wr_n] = imem_wdata;
         end
         wr_n++;
      end
   end

   always @(negedge clk)
      if (imem_we && (done || !cpu_rst)) ovl++;

   task automatic send_byte(input logic [7:0] b, input int gap,
                            input int tmo, output bit ok);
      ok = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < tmo; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_img(input int n, input int gap, input string tag);
      bit ok;
      for (int i = 0; i < n; i++) begin
         send_byte(img[i], gap, 20, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s accept byte %0d: got not-accepted, need accepted", tag, i);
         end
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b0;
      #3;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      rst = 1'b0;
      #13;
      checks++;
      if ({in_ready, imem_we, cpu_rst, done, err} !== 5'b00100) begin
         errors++;
         $display("FAIL reset flags: got rdy/we/crst/done/err=%b, need 00100",
                  {in_ready, imem_we, cpu_rst, done, err});
      end
      checks++;
      if (imem_addr !== '0 || imem_wdata !== '0 || words_loaded !== '0) begin
         errors++;
         $display("FAIL reset regs: got addr=%h wdata=%h wl=%0d, need 0/0/0",
                  imem_addr, imem_wdata, words_loaded);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready after reset: got %b, need 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_image(input int gap, input string tag);
      bit ok;
      do_reset();
      send_img(10, gap, tag);
      checks++;
      if ({imem_we, done, cpu_rst, in_ready} !== 4'b1010) begin
         errors++;
         $display("FAIL %s last strobe: got we/done/crst/rdy=%b, need 1010",
                  tag, {imem_we, done, cpu_rst, in_ready});
      end
      @(posedge clk);
      #1;
`ifdef BOOT_CHECKSUM_EN
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s chk wait: got done=%b rdy=%b, need 0/1", tag, done, in_ready);
      end
      send_byte(8'h19, 0, 20, ok);
`endif
      checks++;
      if ({done, cpu_rst, err, imem_we} !== 4'b1000) begin
         errors++;
         $display("FAIL %s final: got done/crst/err/we=%b, need 1000",
                  tag, {done, cpu_rst, err, imem_we});
      end
      checks++;
      if (words_loaded !== 9'd2) begin
         errors++;
         $display("FAIL %s words_loaded: got %0d, need 2", tag, words_loaded);
      end
      checks++;
      if (wr_n !== 2) begin
         errors++;
         $display("FAIL %s write count: got %0d, need 2", tag, wr_n);
      end
      checks++;
      if (wr_a[0] !== 8'd0 || wr_d[0] !== 32'h00000013 ||
          wr_a[1] !== 8'd1 || wr_d[1] !== 32'h00000008) begin
         errors++;
         $display("FAIL %s writes: got [%0d]=%h [%0d]=%h, need [0]=00000013 [1]=00000008",
                  tag, wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
      send_byte(8'h19, 0, 4, ok);
      checks++;
      if (ok || wr_n !== 2 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s extra byte: got ok=%b writes=%0d done=%b, need 0/2/1",
                  tag, ok, wr_n, done);
      end
   endtask

   task automatic test_empty();
      bit ok;
      do_reset();
      send_byte(8'h00, 0, 20, ok);
      send_byte(8'h00, 0, 20, ok);
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'h00, 0, 20, ok);
`endif
      checks++;
      if ({ok, done, cpu_rst, in_ready} !== 4'b1100) begin
         errors++;
         $display("FAIL empty: got ok/done/crst/rdy=%b, need 1100",
                  {ok, done, cpu_rst, in_ready});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wr_n !== 0 || words_loaded !== '0) begin
         errors++;
         $display("FAIL empty writes: got %0d wl=%0d, need 0/0", wr_n, words_loaded);
      end
   endtask

   task automatic test_oversize();
      bit ok;
      do_reset();
      send_byte(8'h01, 0, 20, ok);
      send_byte(8'h01, 0, 20, ok);
      checks++;
      if ({ok, err, in_ready, cpu_rst, done} !== 5'b11010) begin
         errors++;
         $display("FAIL oversize: got ok/err/rdy/crst/done=%b, need 11010",
                  {ok, err, in_ready, cpu_rst, done});
      end
      send_byte(8'h13, 0, 5, ok);
      checks++;
      if (ok || wr_n !== 0 || err !== 1'b1 || cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL oversize later: got ok=%b writes=%0d err=%b crst=%b, need 0/0/1/1",
                  ok, wr_n, err, cpu_rst);
      end
   endtask

   task automatic test_abort();
      do_reset();
      send_img(7, 0, "abort");
      checks++;
      if (wr_n !== 1 || words_loaded !== 9'd1) begin
         errors++;
         $display("FAIL abort partial: got writes=%0d wl=%0d, need 1/1", wr_n, words_loaded);
      end
      rst = 1'b0;
      #2;
      checks++;
      if ({imem_we, cpu_rst, done, err, in_ready} !== 5'b01000 ||
          words_loaded !== '0 || imem_wdata !== '0) begin
         errors++;
         $display("FAIL abort reset: got we/crst/done/err/rdy=%b wl=%0d wdata=%h, need 01000/0/0",
                  {imem_we, cpu_rst, done, err, in_ready}, words_loaded, imem_wdata);
      end
      test_image(0, "reload");
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_bad_checksum();
      bit ok;
      do_reset();
      send_img(10, 0, "badchk");
      @(posedge clk);
      #1;
      send_byte(8'h18, 0, 20, ok);
      checks++;
      if ({ok, err, cpu_rst, done, in_ready} !== 5'b11100) begin
         errors++;
         $display("FAIL bad checksum: got ok/err/crst/done/rdy=%b, need 11100",
                  {ok, err, cpu_rst, done, in_ready});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_image(0, "basic");
      test_empty();
      test_oversize();
      test_image(1, "throttled");
      test_abort();
`ifdef BOOT_CHECKSUM_EN
      test_bad_checksum();
`endif
      checks++;
      if (ovl !== 0) begin
         errors++;
         $display("FAIL strobe overlap: got %0d cycles with we and release, need 0", ovl);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
